// File: rtl/serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// serial_pattern_detector
//
// Purpose:
//   Samples a serial bit stream (the Q output of the upstream gated D-latch)
//   on every rising CLK edge where E is high. It searches that stream for a
//   fixed PAT_LEN-bit PATTERN. The first bit received is compared against the
//   PATTERN MSB. Each completed pattern produces a one-cycle MATCH pulse and
//   advances a saturating match counter.
//
// Parameters:
//   PAT_LEN  - pattern length in bits (2..16)
//   PATTERN  - pattern to detect, MSB is the oldest bit
//   OVERLAP  - 1: history kept after a match (overlapping matches)
//              0: history and fill discarded on every match
//   CNT_W    - width of the match counter
//
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   asynchronous active-low reset
//   E      in   sample enable, one bit accepted per CLK edge with E=1
//   D      in   serial data bit
//   CLR    in   synchronous clear of history, counter and flags (beats E)
//   MATCH  out  registered one-cycle pulse, pattern completed on last edge
//   COUNT  out  matches since reset/CLR, saturating at 2^CNT_W-1
//   SAT    out  high while COUNT sits at its maximum
//   FILL   out  number of valid history bits (0..PAT_LEN), for debug
//
// All outputs are driven straight from flops. There is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module serial_pattern_detector #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8,
    localparam int unsigned       FILL_W  = $clog2(PAT_LEN + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              E,
    input  logic              D,
    input  logic              CLR,
    output logic              MATCH,
    output logic [CNT_W-1:0]  COUNT,
    output logic              SAT,
    output logic [FILL_W-1:0] FILL
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] history_q, history_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    logic               match_q, match_d;

    // Candidate values for an accepted bit
    logic [PAT_LEN-1:0] history_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    always_comb begin
        // Shift form keeps every history bit in use; the MSB simply falls off.
        history_shift = (history_q << 1) | {{(PAT_LEN-1){1'b0}}, D};
        fill_inc      = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

        // FILL gates the compare so reset zeros can never fake a match,
        // which matters when PATTERN itself is all zeros.
        hit = (fill_inc == FILL_FULL) && (history_shift == PATTERN);

        history_d = history_q;
        fill_d    = fill_q;
        count_d   = count_q;
        match_d   = 1'b0;

        if (CLR) begin
            history_d = '0;
            fill_d    = '0;
            count_d   = '0;
        end else if (E) begin
            history_d = history_shift;
            fill_d    = fill_inc;
            if (hit) begin
                match_d = 1'b1;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (!OVERLAP) begin
                    history_d = '0;
                    fill_d    = '0;
                end
            end
        end

        // SAT mirrors the next counter value, so it rises on the same edge
        // COUNT reaches its maximum and falls only through CLR or reset.
        sat_d = (count_d == CNT_MAX);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            history_q <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            match_q   <= match_d;
        end
    end

    assign MATCH = match_q;
    assign COUNT = count_q;
    assign SAT   = sat_q;
    assign FILL  = fill_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_detector
//
// Four detector instances share one stimulus stream:
//   cfg 0 : defaults (1011, overlapping, 8-bit counter)
//   cfg 1 : OVERLAP=0
//   cfg 2 : PATTERN=4'b0000
//   cfg 3 : CNT_W=2
// A queue-based reference model tracks the accepted bits of each instance.
// -----------------------------------------------------------------------------
module tb_serial_pattern_detector;

    localparam int NC = 4;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic E = 1'b0;
    logic D = 1'b0;
    logic CLR = 1'b0;

    logic       m0, m1, m2, m3;
    logic       s0, s1, s2, s3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic [2:0] f0, f1, f2, f3;

    always #5 CLK = ~CLK;

    serial_pattern_detector u0 (
        .CLK(CLK), .RST_N(RST_N), .E(E), .D(D), .CLR(CLR),
        .MATCH(m0), .COUNT(c0), .SAT(s0), .FILL(f0));

    serial_pattern_detector #(.OVERLAP(1'b0)) u1 (
        .CLK(CLK), .RST_N(RST_N), .E(E), .D(D), .CLR(CLR),
        .MATCH(m1), .COUNT(c1), .SAT(s1), .FILL(f1));

    serial_pattern_detector #(.PATTERN(4'b0000)) u2 (
        .CLK(CLK), .RST_N(RST_N), .E(E), .D(D), .CLR(CLR),
        .MATCH(m2), .COUNT(c2), .SAT(s2), .FILL(f2));

    serial_pattern_detector #(.CNT_W(2)) u3 (
        .CLK(CLK), .RST_N(RST_N), .E(E), .D(D), .CLR(CLR),
        .MATCH(m3), .COUNT(c3), .SAT(s3), .FILL(f3));

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit hist [NC][$];
    int nmatch [NC];
    bit exp_match [NC];

    function automatic int cfg_pat(int c);
        return (c == 2) ? 0 : 11;
    endfunction

    function automatic bit cfg_ovl(int c);
        return (c == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic int cfg_max(int c);
        return (c == 3) ? 3 : 255;
    endfunction

    function automatic int exp_count(int c);
        return (nmatch[c] < cfg_max(c)) ? nmatch[c] : cfg_max(c);
    endfunction

    function automatic bit tail_is_pattern(int c);
        bit ok;
        int sz;
        sz = hist[c].size();
        if (sz < 4) return 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (hist[c][sz-4+k] != 1'((cfg_pat(c) >> (3 - k)) & 1)) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            hist[c].delete();
            nmatch[c] = 0;
            exp_match[c] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit e, input bit d, input bit clr);
        for (int c = 0; c < NC; c++) begin
            exp_match[c] = 1'b0;
            if (clr) begin
                hist[c].delete();
                nmatch[c] = 0;
            end else if (e) begin
                hist[c].push_back(d);
                if (hist[c].size() > 4) void'(hist[c].pop_front());
                if (tail_is_pattern(c)) begin
                    exp_match[c] = 1'b1;
                    nmatch[c]++;
                    if (!cfg_ovl(c)) hist[c].delete();
                end
            end
        end
    endtask

    // ---------------- DUT accessors ----------------
    function automatic int dut_match(int c);
        case (c)
            0: return int'(m0);
            1: return int'(m1);
            2: return int'(m2);
            default: return int'(m3);
        endcase
    endfunction

    function automatic int dut_count(int c);
        case (c)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    function automatic int dut_sat(int c);
        case (c)
            0: return int'(s0);
            1: return int'(s1);
            2: return int'(s2);
            default: return int'(s3);
        endcase
    endfunction

    function automatic int dut_fill(int c);
        case (c)
            0: return int'(f0);
            1: return int'(f1);
            2: return int'(f2);
            default: return int'(f3);
        endcase
    endfunction

    task automatic chk(input string name, input int c, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cfg=%0d t=%0t got=%0d expected=%0d", name, c, $time, got, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge CLK) begin
        if (!RST_N) model_reset();
        else model_edge(E, D, CLR);
        #1;
        for (int c = 0; c < NC; c++) begin
            chk("match", c, dut_match(c), int'(exp_match[c]));
            chk("count", c, dut_count(c), exp_count(c));
            chk("sat",   c, dut_sat(c),   int'(exp_count(c) == cfg_max(c)));
            chk("fill",  c, dut_fill(c),  hist[c].size());
        end
    end

    always @(negedge RST_N) model_reset();

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit e, input bit d, input bit clr);
        @(negedge CLK);
        E = e;
        D = d;
        CLR = clr;
        @(posedge CLK);
        #2;
    endtask

    // Async reset pulse placed between edges; outputs must clear at once.
    task automatic reset_pulse();
        #1 RST_N = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) begin
            chk("rst_match", c, dut_match(c), 0);
            chk("rst_count", c, dut_count(c), 0);
            chk("rst_sat",   c, dut_sat(c),   0);
            chk("rst_fill",  c, dut_fill(c),  0);
        end
        RST_N = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit stream7 [7];
        bit gap_bits [4];
        bit cnt_bits [16];
        int pulses;
        bit tog;

        model_reset();
        repeat (3) @(posedge CLK);
        #2;
        chk("init_count", 0, int'(c0), 0);
        chk("init_fill",  0, int'(f0), 0);
        chk("init_match", 0, int'(m0), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Stream 1,0,1,1,0,1,1
        stream7 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream7[i], 1'b0);
            if (i == 2) chk("lit_nomatch_e3", 0, int'(m0), 0);
            if (i == 3) begin
                chk("lit_match_e4",     0, int'(m0), 1);
                chk("lit_match_e4",     1, int'(m1), 1);
                chk("lit_fill_e4_novl", 1, int'(f1), 0);
            end
        end
        chk("lit_match_e7",     0, int'(m0), 1);
        chk("lit_match_e7",     1, int'(m1), 0);
        chk("lit_count_e7",     0, int'(c0), 2);
        chk("lit_count_e7",     1, int'(c1), 1);
        chk("lit_fill_e7_novl", 1, int'(f1), 3);
        chk("lit_sat_e7",       0, int'(s0), 0);

        // E gaps with D toggling in between
        step(1'b0, 1'b0, 1'b1);
        gap_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        pulses = 0;
        tog = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, gap_bits[i], 1'b0);
            pulses += int'(m0);
            if (i == 3) chk("lit_gap_match", 0, int'(m0), 1);
            for (int g = 0; g < 3; g++) begin
                tog = ~tog;
                step(1'b0, tog, 1'b0);
                pulses += int'(m0);
            end
        end
        chk("lit_gap_pulses", 0, pulses, 1);
        chk("lit_gap_count",  0, int'(c0), 1);

        // All-zero pattern needs four genuinely accepted zeros
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("lit_zero_match", 2, int'(m2), (i == 3) ? 1 : 0);
            chk("lit_zero_count", 2, int'(c2), (i == 3) ? 1 : 0);
        end

        // Five overlapping matches against a 2-bit counter
        step(1'b0, 1'b0, 1'b1);
        cnt_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            step(1'b1, cnt_bits[i], 1'b0);
            if (i >= 3 && (i % 3) == 0) begin
                chk("lit_sat_match", 3, int'(m3), 1);
                chk("lit_sat_count", 3, int'(c3), ((i / 3) < 3) ? (i / 3) : 3);
                chk("lit_sat_flag",  3, int'(s3), ((i / 3) >= 3) ? 1 : 0);
            end
        end
        step(1'b1, 1'b1, 1'b1);
        chk("lit_clr_count", 3, int'(c3), 0);
        chk("lit_clr_sat",   3, int'(s3), 0);
        chk("lit_clr_fill",  3, int'(f3), 0);
        chk("lit_clr_match", 3, int'(m3), 0);

        // Reset in the middle of a partial sequence
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        reset_pulse();
        step(1'b1, 1'b1, 1'b0);
        chk("lit_post_rst_nomatch", 0, int'(m0), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("lit_post_rst_nomatch", 0, int'(m0), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("lit_post_rst_nomatch", 0, int'(m0), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("lit_post_rst_match", 0, int'(m0), 1);
        chk("lit_post_rst_count", 0, int'(c0), 1);

        // Randomised traffic, biased toward pattern-rich streams
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 99) == 0));
            if ($urandom_range(0, 299) == 0) reset_pulse();
        end

        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
